// File: rtl/freq_pkg.sv
// ============================================================================
// Module      : freq_pkg
// Description : Shared seven-segment constants, limits and FSM state encoding
//               for the frequency meter display path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package freq_pkg;

    localparam int NUM_DIGITS  = 6;
    localparam int MAX_DISPLAY = 999999;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_UPDATE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// Module      : seg7_decode
// Description : BCD nibble to active-low seven-segment pattern, with blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decode
    import freq_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else if (i_bcd <= 4'd9) begin
            o_seg = SEG_DIGIT[i_bcd];
        end
    end

endmodule

`default_nettype wire

// File: rtl/freq_bcd_display.sv
// ============================================================================
// Module      : freq_bcd_display
// Description : Iterative double-dabble conversion of the frequency count to
//               six registered seven-segment digits with overflow display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_bcd_display
    import freq_pkg::*;
#(
    parameter int WIDTH    = 20,
    parameter int BLANK_LZ = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value,
    input  logic             value_valid,
    output logic             busy,
    output logic             overflow,
    output logic [6:0]       disp1,
    output logic [6:0]       disp2,
    output logic [6:0]       disp3,
    output logic [6:0]       disp4,
    output logic [6:0]       disp5,
    output logic [6:0]       disp6
);

    localparam logic [WIDTH-1:0] c_max_value = WIDTH'(MAX_DISPLAY);
    localparam logic [5:0]       c_last_iter = 6'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shift;
    logic [23:0]      r_bcd;
    logic [5:0]       r_cnt;
    logic             r_ovf_pend;
    logic             r_overflow;
    logic [6:0]       r_disp [NUM_DIGITS];
    logic [6:0]       w_seg  [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_blank;
    logic             w_lead;
    logic             w_too_big;
    logic [19:0]      w_bcd_adj;
    logic [2:0]       w_adj_top;

    assign w_too_big = (value > c_max_value);

    // Add-3 on the lower five nibbles; the top nibble's MSB is shifted out,
    // so only its low three bits are kept (the range pre-check makes it zero).
    for (genvar gi = 0; gi < NUM_DIGITS - 1; gi++) begin : g_adj
        assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5)
                                    ? r_bcd[gi*4 +: 4] + 4'd3
                                    : r_bcd[gi*4 +: 4];
    end
    assign w_adj_top = (r_bcd[23:20] >= 4'd5) ? r_bcd[22:20] + 3'd3 : r_bcd[22:20];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (value_valid) w_next = w_too_big ? ST_UPDATE : ST_CONVERT;
            ST_CONVERT: if (r_cnt == c_last_iter) w_next = ST_UPDATE;
            ST_UPDATE:  w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // A digit is blanked only while it and every higher digit are zero.
    always_comb begin
        w_blank = '0;
        w_lead  = (BLANK_LZ != 0);
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_lead     = w_lead && (r_bcd[i*4 +: 4] == 4'd0);
            w_blank[i] = w_lead;
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
        seg7_decode u_dec (
            .i_bcd   (r_bcd[gi*4 +: 4]),
            .i_blank (w_blank[gi]),
            .o_seg   (w_seg[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_overflow <= 1'b0;
            r_disp[0]  <= SEG_DIGIT[0];
            for (int i = 1; i < NUM_DIGITS; i++) begin
                r_disp[i] <= (BLANK_LZ != 0) ? SEG_BLANK : SEG_DIGIT[0];
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (value_valid) begin
                        r_ovf_pend <= w_too_big;
                        r_shift    <= value;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                    end
                end
                ST_CONVERT: begin
                    r_bcd   <= {w_adj_top, w_bcd_adj, r_shift[WIDTH-1]};
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                    r_cnt   <= r_cnt + 6'd1;
                end
                ST_UPDATE: begin
                    r_overflow <= r_ovf_pend;
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        r_disp[i] <= r_ovf_pend ? SEG_DASH : w_seg[i];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign overflow = r_overflow;
    assign disp1    = r_disp[0];
    assign disp2    = r_disp[1];
    assign disp3    = r_disp[2];
    assign disp4    = r_disp[3];
    assign disp5    = r_disp[4];
    assign disp6    = r_disp[5];

endmodule

`default_nettype wire

// File: doc/freq_bcd_display.md
# freq_bcd_display

Downstream stage of the frequency meter. Takes the binary frequency count produced each gate window and converts it to six decimal digits using an iterative shift-add-3 (double-dabble) FSM. Drives the six active-low 7-segment outputs `disp1`..`disp6`, with optional leading-zero blanking and an overflow indication. The last value stays displayed until a new conversion completes.

## Interface
- `WIDTH`, 20: width of the binary input count; legal range 20..32.
- `BLANK_LZ`, 1: when 1, leading-zero digits are blanked; when 0, all six digits are always shown.

- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active-high.
- `value` in WIDTH: binary frequency count (Hz).
- `value_valid` in 1: single-cycle strobe; `value` is sampled on the same edge.
- `busy` out 1: high while a conversion is in progress.
- `overflow` out 1: high while the displayed value is the overflow pattern.
- `disp1` out 7: units digit.
- `disp2`..`disp6` out 7 each: tens through hundred-thousands digits.

Segment encoding:
- All segments are active-low, bit order {g,f,e,d,c,b,a} (bit0 = a).
- Digits 0..9 = 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78, 0x00, 0x10.
- Blank = 0x7F; dash = 0x3F.

## Operation
The FSM has three states: IDLE, CONVERT, UPDATE.

- **IDLE, `value_valid`=1:**
  - If `value` > 999999: set the overflow flag internally and go to UPDATE.
  - Otherwise: load the shift register with `value`, clear the 24-bit BCD accumulator and the iteration counter, then go to CONVERT.
- **CONVERT:** each cycle performs one iteration:
  - Every BCD nibble ≥ 5 gets +3.
  - Then {bcd, shift} shifts left by 1.
  - The counter increments.
  - After exactly WIDTH iterations, go to UPDATE.
- **UPDATE:** register all display outputs from the BCD accumulator (or the overflow pattern), update `overflow`, and return to IDLE.
- **`value_valid` while not IDLE:** ignored (sample dropped). There is no queuing.
- **Overflow pattern:** all six digits show dash (0x3F) and `overflow`=1. Any non-overflow update clears `overflow`.
- **Leading-zero blanking (`BLANK_LZ`=1):** digit k (k = 2..6) is blank if it and all higher digits are 0. `disp1` is never blanked.
- **Arithmetic:** the BCD accumulator is 24 bits (6 nibbles). The >999999 pre-check guarantees no carry out of the top nibble. The comparison is done at full WIDTH.

## Timing
- **Reset values:**
  - `busy`=0, `overflow`=0, state IDLE.
  - `disp1`=0x40.
  - `disp2`..`disp6` = 0x7F if `BLANK_LZ`=1, else 0x40.
- **Normal latency:** `value_valid` is sampled at edge E0; iterations run on E1..E_WIDTH; displays update at edge E_(WIDTH+1). With WIDTH=20, new digits are visible 21 cycles after the sampling edge.
- **Overflow latency:** displays update at E1.
- **`busy`:** rises after E0 and falls after the UPDATE edge. A new strobe is accepted in the cycle after `busy` falls, giving a maximum accept rate of 1 per WIDTH+2 cycles.
- **Reset mid-conversion:** the conversion is aborted, all outputs return to their reset values on the next edge, and the partial result is discarded.
- **Simultaneous `rst` and `value_valid`:** reset wins.
- **Display stability:** `disp*` and `overflow` change only on the UPDATE edge or on reset. They never glitch during CONVERT.

## Structure
- **Shared package `freq_pkg`:**
  - The seven-segment constants: SEG_DIGIT[0:9], SEG_BLANK, SEG_DASH.
  - MAX_DISPLAY = 999999.
  - NUM_DIGITS = 6.
  - The FSM state enum.
- **Sub-module `seg7_decode`:** combinational; inputs are a 4-bit BCD nibble and a blank flag; output is 7-bit segments. Instantiated six times.
- **Top level:** contains the FSM, the shift/BCD registers, the iteration counter and the blanking logic.

## Test plan
- **Reset:** assert `rst` 2 cycles → `disp1`=0x40, `disp2`..`disp6`=0x7F, `busy`=0, `overflow`=0.
- **123456:** `value`=123456 with strobe → 21 cycles later `disp6`..`disp1` = 0x79, 0x24, 0x30, 0x19, 0x12, 0x02; `busy` high for exactly 21 cycles.
- **Leading-zero blanking:** `value`=500 → `disp1`=0x40, `disp2`=0x40, `disp3`=0x12, `disp4`..`disp6`=0x7F. Repeat with `BLANK_LZ`=0 → `disp4`..`disp6`=0x40.
- **Overflow boundary:**
  - `value`=999999 → all digits 0x10, `overflow`=0.
  - `value`=1000000 → all digits 0x3F, `overflow`=1 after 1 cycle.
  - A following `value`=7 → `overflow`=0, `disp1`=0x78.
- **Dropped strobe:** second strobe with `value`=42 five cycles after the first strobe (`value`=8) → ignored; display shows 8; `busy` timing is unchanged.
- **Reset mid-conversion:** `rst` at cycle 10 of a conversion of 654321 → outputs return to reset values; no later update occurs.
